// File: rtl/mem_responder.sv
// Memory-side responder: sequences the asynchronous board SRAM for CPU read/write
// requests and services one memory-mapped I/O address (switches in, hex display out).
module mem_responder #(
  parameter logic [15:0] IO_ADDR = 16'hFFFF,
  parameter logic [3:0]  ADDR_HI = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_in,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Busy,
  output logic [15:0] Hex_out,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ACCESS  = 3'd1,
    RD_HOLD    = 3'd2,
    WR_SETUP   = 3'd3,
    WR_PULSE   = 3'd4,
    WR_RECOVER = 3'd5,
    WAIT_REL   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic [15:0] sw_meta_q, sw_meta_d;
  logic [15:0] sw_sync_q, sw_sync_d;

  logic        is_io;
  logic        dq_oe;
  logic        ce_n, oe_n, we_n, bytes_n;
  logic [15:0] data_out;

  assign is_io = (addr_q == IO_ADDR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      rdata_q   <= 16'h0000;
      hex_q     <= 16'h0000;
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hex_q     <= hex_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  // Strobes and DQ enable are pure decodes of state_q so reset releases them at once.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    hex_d     = hex_q;
    sw_meta_d = Switches;
    sw_sync_d = sw_meta_q;
    ce_n      = 1'b1;
    oe_n      = 1'b1;
    we_n      = 1'b1;
    bytes_n   = 1'b1;
    dq_oe     = 1'b0;
    data_out  = rdata_q;

    case (state_q)
      IDLE: begin
        if (Mem_WE) begin
          addr_d  = MAR;
          wdata_d = MDR_in;
          state_d = WR_SETUP;
        end else if (Mem_OE) begin
          addr_d  = MAR;
          state_d = RD_ACCESS;
        end
      end
      RD_ACCESS: begin
        if (is_io) begin
          data_out = sw_sync_q;
          rdata_d  = sw_sync_q;
        end else begin
          ce_n     = 1'b0;
          oe_n     = 1'b0;
          bytes_n  = 1'b0;
          data_out = SRAM_DQ;
          rdata_d  = SRAM_DQ;
        end
        state_d = RD_HOLD;
      end
      RD_HOLD: begin
        if (!Mem_OE) state_d = IDLE;
      end
      WR_SETUP: begin
        if (!is_io) begin
          ce_n    = 1'b0;
          bytes_n = 1'b0;
          dq_oe   = 1'b1;
        end
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (is_io) begin
          hex_d = wdata_q;
        end else begin
          ce_n    = 1'b0;
          bytes_n = 1'b0;
          we_n    = 1'b0;
          dq_oe   = 1'b1;
        end
        state_d = WR_RECOVER;
      end
      WR_RECOVER: begin
        // Data and chip enable held one cycle past the WE_N rising edge.
        if (!is_io) begin
          ce_n    = 1'b0;
          bytes_n = 1'b0;
          dq_oe   = 1'b1;
        end
        state_d = (Mem_OE || Mem_WE) ? WAIT_REL : IDLE;
      end
      WAIT_REL: begin
        if (!Mem_OE && !Mem_WE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign SRAM_DQ     = dq_oe ? wdata_q : 16'hzzzz;
  assign SRAM_ADDR   = {ADDR_HI, addr_q};
  assign SRAM_CE_N   = ce_n;
  assign SRAM_OE_N   = oe_n;
  assign SRAM_WE_N   = we_n;
  assign SRAM_UB_N   = bytes_n;
  assign SRAM_LB_N   = bytes_n;
  assign Data_to_CPU = data_out;
  assign Busy        = (state_q != IDLE);
  assign Hex_out     = hex_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: SRAM behavioural model on a pulled-up DQ bus,
// per-feature tasks with inline checks, and a reference memory for a mixed sequence.
module tb_mem_responder;

  logic        Clk;
  logic        Reset_n;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR_in;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic        Busy;
  logic [15:0] Hex_out;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  int checks = 0;
  int fails  = 0;

  int we_low_cnt = 0;
  int oe_low_cnt = 0;
  int ce_low_cnt = 0;
  int contention_cnt = 0;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];

  mem_responder dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Mem_OE     (Mem_OE),
    .Mem_WE     (Mem_WE),
    .MAR        (MAR),
    .MDR_in     (MDR_in),
    .Switches   (Switches),
    .Data_to_CPU(Data_to_CPU),
    .Busy       (Busy),
    .Hex_out    (Hex_out),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_OE_N  (SRAM_OE_N),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_UB_N  (SRAM_UB_N),
    .SRAM_LB_N  (SRAM_LB_N)
  );

  // Undriven bus reads as 16'hFFFF, so tri-state is observable as that value.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup (SRAM_DQ[gi]);
  end

  logic sram_drive;
  assign sram_drive = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = sram_drive ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

  always @(posedge SRAM_WE_N) begin
    if (!SRAM_CE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!SRAM_WE_N) we_low_cnt++;
    if (!SRAM_OE_N) oe_low_cnt++;
    if (!SRAM_CE_N) ce_low_cnt++;
    if (!SRAM_OE_N && (!SRAM_WE_N || SRAM_DQ !== mem[SRAM_ADDR[7:0]])) contention_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (!Busy) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL %s_idle_timeout: Busy=%b want 0", name, Busy);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", Busy); end
    checks++;
    if (Data_to_CPU !== 16'h0000) begin fails++; $display("FAIL rst_data: got %h want 0000", Data_to_CPU); end
    checks++;
    if (Hex_out !== 16'h0000) begin fails++; $display("FAIL rst_hex: got %h want 0000", Hex_out); end
    checks++;
    if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111) begin
      fails++;
      $display("FAIL rst_strobes: got %b want 11111",
               {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N});
    end
    checks++;
    if (SRAM_DQ !== 16'hFFFF) begin fails++; $display("FAIL rst_dq_z: got %h want FFFF", SRAM_DQ); end
    $display("reset: Busy=%b Data=%h Hex=%h", Busy, Data_to_CPU, Hex_out);
  endtask

  task automatic test_write_then_read;
    int we0;
    we0 = we_low_cnt;
    Mem_WE = 1'b1; MAR = 16'h0042; MDR_in = 16'hBEEF;
    @(negedge Clk); // c2 WR_SETUP
    checks++;
    if (SRAM_ADDR !== 20'h00042) begin fails++; $display("FAIL wr_addr: got %h want 00042", SRAM_ADDR); end
    checks++;
    if (SRAM_DQ !== 16'hBEEF) begin fails++; $display("FAIL wr_dq_c2: got %h want BEEF", SRAM_DQ); end
    checks++;
    if ({Busy, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N} !== 4'b1011) begin
      fails++; $display("FAIL wr_c2_ctl: got %b want 1011", {Busy, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N});
    end
    @(negedge Clk); // c3 WR_PULSE
    checks++;
    if ({SRAM_WE_N, SRAM_CE_N} !== 2'b00) begin
      fails++; $display("FAIL wr_c3_ctl: got %b want 00", {SRAM_WE_N, SRAM_CE_N});
    end
    checks++;
    if (SRAM_DQ !== 16'hBEEF) begin fails++; $display("FAIL wr_dq_c3: got %h want BEEF", SRAM_DQ); end
    Mem_WE = 1'b0;
    @(negedge Clk); // c4 WR_RECOVER
    checks++;
    if ({Busy, SRAM_CE_N, SRAM_WE_N} !== 3'b101) begin
      fails++; $display("FAIL wr_c4_ctl: got %b want 101", {Busy, SRAM_CE_N, SRAM_WE_N});
    end
    checks++;
    if (SRAM_DQ !== 16'hBEEF) begin fails++; $display("FAIL wr_dq_c4: got %h want BEEF", SRAM_DQ); end
    @(negedge Clk); // c5 IDLE
    checks++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL wr_c5_busy: got %b want 0", Busy); end
    checks++;
    if (SRAM_DQ !== 16'hFFFF) begin fails++; $display("FAIL wr_c5_dq_z: got %h want FFFF", SRAM_DQ); end
    checks++;
    if (we_low_cnt - we0 != 1) begin fails++; $display("FAIL wr_we_pulses: got %0d want 1", we_low_cnt - we0); end
    ref_mem[8'h42] = 16'hBEEF;
    $display("write addr=0042 data=BEEF");

    Mem_OE = 1'b1; MAR = 16'h0042;
    @(negedge Clk); // c2 RD_ACCESS
    checks++;
    if (Data_to_CPU !== 16'hBEEF) begin fails++; $display("FAIL rd_c2_data: got %h want BEEF", Data_to_CPU); end
    checks++;
    if ({Busy, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== 4'b1001) begin
      fails++; $display("FAIL rd_c2_ctl: got %b want 1001", {Busy, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N});
    end
    @(negedge Clk); // c3 RD_HOLD
    checks++;
    if (Data_to_CPU !== 16'hBEEF) begin fails++; $display("FAIL rd_c3_data: got %h want BEEF", Data_to_CPU); end
    checks++;
    if ({Busy, SRAM_OE_N} !== 2'b11) begin fails++; $display("FAIL rd_c3_ctl: got %b want 11", {Busy, SRAM_OE_N}); end
    Mem_OE = 1'b0;
    @(negedge Clk);
    checks++;
    if ({Busy, Data_to_CPU} !== {1'b0, 16'hBEEF}) begin
      fails++; $display("FAIL rd_after: got busy=%b data=%h want 0/BEEF", Busy, Data_to_CPU);
    end
    $display("read addr=0042 data=%h", Data_to_CPU);
  endtask

  task automatic test_mmio_write;
    int ce0;
    ce0 = ce_low_cnt;
    Mem_WE = 1'b1; MAR = 16'hFFFF; MDR_in = 16'h1234;
    @(negedge Clk); // c2
    checks++;
    if (SRAM_DQ !== 16'hFFFF || Busy !== 1'b1) begin
      fails++; $display("FAIL mmio_wr_c2: got dq=%h busy=%b want FFFF/1", SRAM_DQ, Busy);
    end
    @(negedge Clk); // c3
    checks++;
    if (Hex_out !== 16'h0000) begin fails++; $display("FAIL mmio_hex_c3: got %h want 0000", Hex_out); end
    Mem_WE = 1'b0;
    @(negedge Clk); // c4
    checks++;
    if (Hex_out !== 16'h1234) begin fails++; $display("FAIL mmio_hex_c4: got %h want 1234", Hex_out); end
    wait_idle("mmio_wr");
    #1;
    checks++;
    if (ce_low_cnt != ce0) begin fails++; $display("FAIL mmio_wr_ce: got %0d low cycles want 0", ce_low_cnt - ce0); end
    $display("write addr=FFFF data=1234 hex=%h", Hex_out);
  endtask

  task automatic test_mmio_read;
    int oe0;
    Switches = 16'h00A5;
    repeat (3) @(negedge Clk);
    oe0 = oe_low_cnt;
    Mem_OE = 1'b1; MAR = 16'hFFFF;
    @(negedge Clk); // c2
    checks++;
    if (Data_to_CPU !== 16'h00A5) begin fails++; $display("FAIL mmio_rd_c2: got %h want 00A5", Data_to_CPU); end
    @(negedge Clk); // c3
    checks++;
    if (Data_to_CPU !== 16'h00A5) begin fails++; $display("FAIL mmio_rd_c3: got %h want 00A5", Data_to_CPU); end
    Mem_OE = 1'b0;
    wait_idle("mmio_rd");
    #1;
    checks++;
    if (oe_low_cnt != oe0) begin fails++; $display("FAIL mmio_rd_oe: got %0d low cycles want 0", oe_low_cnt - oe0); end
    $display("read addr=FFFF data=%h", Data_to_CPU);
  endtask

  task automatic test_reset_mid_write;
    Mem_WE = 1'b1; MAR = 16'h0077; MDR_in = 16'h5555;
    @(negedge Clk);
    @(negedge Clk); // c3 WR_PULSE
    checks++;
    if (SRAM_WE_N !== 1'b0) begin fails++; $display("FAIL rmw_pulse: got WE_N=%b want 0", SRAM_WE_N); end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (SRAM_WE_N !== 1'b1) begin fails++; $display("FAIL rmw_we_n: got %b want 1", SRAM_WE_N); end
    checks++;
    if (SRAM_DQ !== 16'hFFFF) begin fails++; $display("FAIL rmw_dq_z: got %h want FFFF", SRAM_DQ); end
    Mem_WE = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL rmw_busy: got %b want 0", Busy); end
    checks++;
    if (Hex_out !== 16'h0000) begin fails++; $display("FAIL rmw_hex: got %h want 0000", Hex_out); end
    checks++;
    if (Data_to_CPU !== 16'h0000) begin fails++; $display("FAIL rmw_data: got %h want 0000", Data_to_CPU); end
    $display("reset during write pulse: Busy=%b Hex=%h", Busy, Hex_out);
  endtask

  task automatic test_priority;
    int oe0, we0;
    oe0 = oe_low_cnt; we0 = we_low_cnt;
    Mem_OE = 1'b1; Mem_WE = 1'b1; MAR = 16'h0050; MDR_in = 16'h1357;
    @(negedge Clk); // c2
    checks++;
    if (SRAM_DQ !== 16'h1357 || SRAM_OE_N !== 1'b1) begin
      fails++; $display("FAIL prio_c2: got dq=%h oe_n=%b want 1357/1", SRAM_DQ, SRAM_OE_N);
    end
    @(negedge Clk);
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    wait_idle("prio");
    #1;
    checks++;
    if (oe_low_cnt != oe0 || we_low_cnt - we0 != 1) begin
      fails++; $display("FAIL prio_pulses: got oe=%0d we=%0d want 0/1", oe_low_cnt - oe0, we_low_cnt - we0);
    end
    ref_mem[8'h50] = 16'h1357;
    $display("write (OE+WE) addr=0050 data=1357");
  endtask

  task automatic test_hold_off;
    int we0;
    we0 = we_low_cnt;
    Mem_WE = 1'b1; MAR = 16'h0060; MDR_in = 16'h2468;
    repeat (4) @(negedge Clk); // c5
    checks++;
    if ({Busy, SRAM_CE_N, SRAM_WE_N} !== 3'b111 || SRAM_DQ !== 16'hFFFF) begin
      fails++; $display("FAIL hold_c5: got busy/ce_n/we_n=%b dq=%h want 111/FFFF",
                        {Busy, SRAM_CE_N, SRAM_WE_N}, SRAM_DQ);
    end
    @(negedge Clk); // c6
    checks++;
    if (Busy !== 1'b1) begin fails++; $display("FAIL hold_c6_busy: got %b want 1", Busy); end
    Mem_WE = 1'b0;
    @(negedge Clk); // c7
    checks++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL hold_c7_busy: got %b want 0", Busy); end
    checks++;
    if (we_low_cnt - we0 != 1) begin fails++; $display("FAIL hold_we_pulses: got %0d want 1", we_low_cnt - we0); end
    ref_mem[8'h60] = 16'h2468;
    $display("write (held 6) addr=0060 data=2468");
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, d, rd2;
    bit wr;
    int c0;
    c0 = contention_cnt;
    for (int n = 0; n < 50; n++) begin
      wr = $urandom_range(0, 1) == 1;
      a  = 16'h0010 + 16'($urandom_range(0, 7));
      d  = 16'($urandom_range(0, 16'hFFFE));
      Mem_WE = wr; Mem_OE = !wr; MAR = a; MDR_in = d;
      @(negedge Clk);
      rd2 = Data_to_CPU;
      @(negedge Clk);
      Mem_WE = 1'b0; Mem_OE = 1'b0;
      wait_idle("b2b");
      if (wr) begin
        ref_mem[a[7:0]] = d;
        $display("op %0d write addr=%h data=%h", n, a, d);
      end else begin
        checks++;
        if (rd2 !== ref_mem[a[7:0]]) begin
          fails++; $display("FAIL b2b_read_%0d: addr=%h got %h want %h", n, a, rd2, ref_mem[a[7:0]]);
        end
        $display("op %0d read addr=%h data=%h", n, a, rd2);
      end
    end
    #1;
    checks++;
    if (contention_cnt != c0) begin fails++; $display("FAIL b2b_contention: got %0d cycles want 0", contention_cnt - c0); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    Reset_n = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
    MAR = 16'h0000; MDR_in = 16'h0000; Switches = 16'h0000;
    repeat (3) @(negedge Clk);
    test_reset();
    Reset_n = 1'b1;
    @(negedge Clk);
    test_write_then_read();
    @(negedge Clk);
    test_mmio_write();
    test_reset_mid_write();
    test_priority();
    test_hold_off();
    test_mmio_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the LC-3 datapath. It answers the control unit's level-sensitive `Mem_OE`/`Mem_WE` requests by sequencing the external asynchronous SRAM through setup, strobe and recovery cycles. It also services one memory-mapped I/O address: reads return the board switches, and writes load the hex-display register. It sits between the CPU's MAR/MDR and the board SRAM pins.

## Interface
- `IO_ADDR`, 16'hFFFF, the memory-mapped I/O address; accesses to it never touch the SRAM.
- `ADDR_HI`, 4'h0, constant upper bits of `SRAM_ADDR[19:16]`.
- `Clk` in 1: single system clock; every register is clocked on the rising edge.
- `Reset_n` in 1: one clock domain. Reset is asynchronous and active-low.
- `Mem_OE` in 1: read request, active high, held by the CPU for 3 cycles.
- `Mem_WE` in 1: write request, active high, held by the CPU for 3 cycles.
- `MAR` in 16: access address.
- `MDR_in` in 16: write data from the CPU.
- `Switches` in 16: asynchronous board switches.
- `Data_to_CPU` out 16: read data driven to the MDR input mux.
- `Busy` out 1: high in every state except IDLE.
- `Hex_out` out 16: hex-display register.
- `SRAM_ADDR` out 20: `{ADDR_HI, latched MAR}`.
- `SRAM_DQ` inout 16: SRAM data bus, tri-stated unless writing.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: active-low SRAM strobes.

## Operation
- FSM states: IDLE, RD_ACCESS, RD_HOLD, WR_SETUP, WR_PULSE, WR_RECOVER, WAIT_REL.
- **IDLE**
  - All strobes are high and DQ is tri-stated.
  - Sampled `Mem_WE`=1: latch `MAR`→addr_q and `MDR_in`→wdata_q, go to WR_SETUP.
  - Else sampled `Mem_OE`=1: latch `MAR`, go to RD_ACCESS.
  - `Mem_WE` has priority when both are high.
- **RD_ACCESS** (SRAM address): `CE_N`=`OE_N`=`UB_N`=`LB_N`=0.
  - `Data_to_CPU` = `SRAM_DQ`, combinational bypass.
  - At the cycle end, `SRAM_DQ` is captured into rdata_q. Go to RD_HOLD.
- **RD_ACCESS** (IO_ADDR): no strobes.
  - `Data_to_CPU` = sw_sync, the output of the 2-flop `Switches` synchronizer.
  - sw_sync is captured into rdata_q.
- **RD_HOLD**
  - Strobes are high and `Data_to_CPU` = rdata_q.
  - Stay while `Mem_OE`=1; go to IDLE when it drops.
- **Outside RD_ACCESS**, `Data_to_CPU` = rdata_q, which holds the last read value.
- **WR_SETUP**: `CE_N`=`UB_N`=`LB_N`=0, `WE_N`=1, DQ driven with wdata_q.
- **WR_PULSE**
  - SRAM address: same as WR_SETUP but `WE_N`=0.
  - IO_ADDR: no strobes, DQ tri-stated, and `Hex_out` <= wdata_q at the cycle end.
- **WR_RECOVER**
  - `WE_N`=1; `CE_N` and DQ stay driven for one hold cycle.
  - Go to IDLE if `Mem_OE`=`Mem_WE`=0, else go to WAIT_REL.
- **WAIT_REL**: strobes are high and DQ is tri-stated. Go to IDLE once both requests are low.
- **New requests** while not in IDLE are ignored; a request is only accepted from IDLE.
- **DQ contention rule**: DQ drive enable and `SRAM_OE_N`=0 are never asserted in the same cycle.
- **Reset** (async, any state): state=IDLE, rdata_q=0, `Hex_out`=0, sw_sync=0, `Busy`=0, all strobes high, DQ tri-stated, `Data_to_CPU`=0.
  - A write interrupted mid-pulse is simply abandoned; `WE_N` rises immediately.

## Timing
- Let c1 be the first cycle `Mem_OE` or `Mem_WE` is high.
- **Read**
  - RD_ACCESS is in c2; `Data_to_CPU` is valid within c2.
  - It stays stable through c3 (RD_HOLD), so CPU `LD_MDR` at the end of c2 or c3 captures correct data.
  - Read latency is one cycle of request to data.
- **Write**
  - WR_SETUP c2, WR_PULSE c3, WR_RECOVER c4. `Busy` is high c2–c4.
  - The SRAM write commits on the `WE_N` rising edge at the start of c4. `Hex_out` updates at the end of c3.
- Back-to-back accesses need one IDLE cycle between release and the next request. The CPU's fetch sequence always provides this.
- Switch reads see `Switches` delayed 2 cycles by the synchronizer.

## Test plan
- Reset mid-write: assert `Reset_n`=0 during WR_PULSE → `SRAM_WE_N`=1 and DQ high-Z in the same cycle. After release, `Busy`=0, `Hex_out`=0.
- Write then read:
  - Write 16'hBEEF to 16'h0042 → `SRAM_ADDR`=20'h00042, `WE_N` low for exactly 1 cycle (c3), DQ=16'hBEEF from c2 to c4.
  - Then read 16'h0042 with the SRAM model returning 16'hBEEF → `Data_to_CPU`=16'hBEEF in c2 and c3.
- MMIO write: write 16'h1234 to 16'hFFFF → `Hex_out`=16'h1234 after c3, and `SRAM_CE_N` stays high throughout.
- MMIO read: `Switches`=16'h00A5 held for 3 or more cycles, read 16'hFFFF → `Data_to_CPU`=16'h00A5 in c2/c3, `SRAM_OE_N` never low.
- Priority and hold-off:
  - `Mem_OE` and `Mem_WE` both high → write sequence, no `OE_N` pulse.
  - `Mem_WE` held 6 cycles → exactly one `WE_N` pulse, then WAIT_REL until the drop.
- Contention check: for a random interleaving of 50 reads and writes, assert that DQ enable and `SRAM_OE_N`=0 are never simultaneous, and that read data matches a reference memory.
